// File: rtl/sd_block_read_sequencer.sv
// sd_block_read_sequencer
// Runs one BLOCK_BYTES-long SD block read on behalf of the bus: waits for the SD
// controller to be ready, issues the read at the latched block address, writes
// each received byte into the sector buffer and reports done / sticky error.
// All outputs come straight from registers. A watchdog aborts the read when
// neither ready nor a byte strobe makes progress for TIMEOUT_CYC cycles.
module sd_block_read_sequencer #(
    parameter int BLOCK_BYTES = 512,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 2**22
) (
    input  logic                           CLOCK_50,
    input  logic                           KEY0,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              addr,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic                           sd_rd,
    output logic [ADDR_W-1:0]              sd_addr,
    input  logic                           sd_ready,
    input  logic                           sd_byte_avail,
    input  logic [7:0]                     sd_dout,
    output logic                           buf_we,
    output logic [$clog2(BLOCK_BYTES)-1:0] buf_waddr,
    output logic [7:0]                     buf_wdata
);

    localparam int IDX_W = $clog2(BLOCK_BYTES);
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BLOCK_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_RECV     = 3'd3,
        ST_FINISH   = 3'd4,
        ST_FAIL     = 3'd5
    } state_t;

    // Registered state
    state_t             state_r;
    logic               busy_r;
    logic               done_r;
    logic               error_r;
    logic               sd_rd_r;
    logic [ADDR_W-1:0]  sd_addr_r;
    logic               buf_we_r;
    logic [IDX_W-1:0]   buf_waddr_r;
    logic [7:0]         buf_wdata_r;
    logic [IDX_W-1:0]   count_r;
    logic [TMO_W-1:0]   tmo_r;
    logic               avail_prev_r;

    // Next-state values
    state_t             state_s;
    logic               busy_s;
    logic               done_s;
    logic               error_s;
    logic               sd_rd_s;
    logic [ADDR_W-1:0]  sd_addr_s;
    logic               buf_we_s;
    logic [IDX_W-1:0]   buf_waddr_s;
    logic [7:0]         buf_wdata_s;
    logic [IDX_W-1:0]   count_s;
    logic [TMO_W-1:0]   tmo_s;

    logic               byte_edge_s;
    logic               tmo_hit_s;

    // A byte is taken only on the rising edge of the strobe, so a level held
    // high for many cycles produces a single write.
    assign byte_edge_s = sd_byte_avail & ~avail_prev_r;
    assign tmo_hit_s   = (tmo_r == TMO_LIMIT);

    // Next-state and next-output logic of the read sequencer
    always_comb begin
        state_s     = state_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        error_s     = error_r;
        sd_rd_s     = sd_rd_r;
        sd_addr_s   = sd_addr_r;
        buf_we_s    = 1'b0;
        buf_waddr_s = buf_waddr_r;
        buf_wdata_s = buf_wdata_r;
        count_s     = count_r;
        tmo_s       = tmo_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    sd_addr_s = addr;
                    error_s   = 1'b0;
                    count_s   = {IDX_W{1'b0}};
                    tmo_s     = {TMO_W{1'b0}};
                    busy_s    = 1'b1;
                    state_s   = ST_WAIT_RDY;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_WAIT_RDY: begin
                if (sd_ready) begin
                    sd_rd_s = 1'b1;
                    tmo_s   = {TMO_W{1'b0}};
                    state_s = ST_ISSUE;
                end else if (tmo_hit_s) begin
                    tmo_s   = {TMO_W{1'b0}};
                    state_s = ST_FAIL;
                end else begin
                    tmo_s = tmo_r + TMO_W'(1);
                end
            end

            ST_ISSUE: begin
                // The controller drops ready once it has taken the request.
                if (!sd_ready) begin
                    sd_rd_s = 1'b0;
                    tmo_s   = {TMO_W{1'b0}};
                    state_s = ST_RECV;
                end else if (tmo_hit_s) begin
                    sd_rd_s = 1'b0;
                    tmo_s   = {TMO_W{1'b0}};
                    state_s = ST_FAIL;
                end else begin
                    tmo_s = tmo_r + TMO_W'(1);
                end
            end

            ST_RECV: begin
                // A byte edge counts as progress even on the timeout cycle.
                if (byte_edge_s) begin
                    buf_we_s    = 1'b1;
                    buf_waddr_s = count_r;
                    buf_wdata_s = sd_dout;
                    tmo_s       = {TMO_W{1'b0}};
                    if (count_r == LAST_IDX) begin
                        state_s = ST_FINISH;
                    end else begin
                        count_s = count_r + IDX_W'(1);
                    end
                end else if (tmo_hit_s) begin
                    tmo_s   = {TMO_W{1'b0}};
                    state_s = ST_FAIL;
                end else begin
                    tmo_s = tmo_r + TMO_W'(1);
                end
            end

            ST_FINISH: begin
                done_s  = 1'b1;
                busy_s  = 1'b0;
                tmo_s   = {TMO_W{1'b0}};
                state_s = ST_IDLE;
            end

            ST_FAIL: begin
                error_s = 1'b1;
                busy_s  = 1'b0;
                sd_rd_s = 1'b0;
                tmo_s   = {TMO_W{1'b0}};
                state_s = ST_IDLE;
            end

            default: begin
                busy_s  = 1'b0;
                sd_rd_s = 1'b0;
                tmo_s   = {TMO_W{1'b0}};
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            sd_rd_r      <= 1'b0;
            sd_addr_r    <= {ADDR_W{1'b0}};
            buf_we_r     <= 1'b0;
            buf_waddr_r  <= {IDX_W{1'b0}};
            buf_wdata_r  <= 8'h00;
            count_r      <= {IDX_W{1'b0}};
            tmo_r        <= {TMO_W{1'b0}};
            avail_prev_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            error_r      <= error_s;
            sd_rd_r      <= sd_rd_s;
            sd_addr_r    <= sd_addr_s;
            buf_we_r     <= buf_we_s;
            buf_waddr_r  <= buf_waddr_s;
            buf_wdata_r  <= buf_wdata_s;
            count_r      <= count_s;
            tmo_r        <= tmo_s;
            avail_prev_r <= sd_byte_avail;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign error     = error_r;
    assign sd_rd     = sd_rd_r;
    assign sd_addr   = sd_addr_r;
    assign buf_we    = buf_we_r;
    assign buf_waddr = buf_waddr_r;
    assign buf_wdata = buf_wdata_r;

endmodule

// File: tb/tb_sd_block_read_sequencer.sv
// Directed testbench for sd_block_read_sequencer (TIMEOUT_CYC reduced to 64).
module tb_sd_block_read_sequencer;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        KEY0;
    logic        start;
    logic [31:0] addr;
    logic        busy, done, error, sd_rd;
    logic [31:0] sd_addr;
    logic        sd_ready;
    logic        sd_byte_avail;
    logic [7:0]  sd_dout;
    logic        buf_we;
    logic [8:0]  buf_waddr;
    logic [7:0]  buf_wdata;

    sd_block_read_sequencer #(
        .BLOCK_BYTES(512),
        .ADDR_W(32),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .CLOCK_50(clk),
        .KEY0(KEY0),
        .start(start),
        .addr(addr),
        .busy(busy),
        .done(done),
        .error(error),
        .sd_rd(sd_rd),
        .sd_addr(sd_addr),
        .sd_ready(sd_ready),
        .sd_byte_avail(sd_byte_avail),
        .sd_dout(sd_dout),
        .buf_we(buf_we),
        .buf_waddr(buf_waddr),
        .buf_wdata(buf_wdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Buffer-side observation, sampled on the falling edge
    int         wr_total   = 0;
    int         done_total = 0;
    int         rd_cycles  = 0;
    int         ord_err    = 0;
    int         prev_waddr = -1;
    logic [7:0] mem [0:511];

    always @(negedge clk) begin
        if (buf_we === 1'b1) begin
            if (!(buf_waddr == 9'd0 || int'(buf_waddr) == prev_waddr + 1))
                ord_err++;
            prev_waddr = int'(buf_waddr);
            mem[buf_waddr] = buf_wdata;
            wr_total++;
        end
        if (done === 1'b1) done_total++;
        if (sd_rd === 1'b1) rd_cycles++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pattern(input int p, input int i);
        case (p)
            0:       return 8'(i);
            1:       return 8'(i * 3);
            2:       return 8'(i) ^ 8'hA5;
            default: return 8'(i + 7);
        endcase
    endfunction

    task automatic begin_read(input logic [31:0] a);
        start = 1'b1;
        addr  = a;
        tick();
        start = 1'b0;
        addr  = ~a;
    endtask

    // Controller model: wait for the request, drop ready to accept it.
    task automatic accept();
        int seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (sd_rd === 1'b1) begin
                seen = 1;
                break;
            end
            tick();
        end
        chk("sd_rd_request", seen, 1);
        sd_ready = 1'b0;
        tick();
        sd_ready = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input int hold);
        sd_dout       = d;
        sd_byte_avail = 1'b1;
        tick();
        sd_dout = ~d;
        repeat (hold - 1) tick();
        sd_byte_avail = 1'b0;
        tick();
    endtask

    task automatic run_bytes(input int pat, input int first, input int last, input int hold);
        for (int i = first; i <= last; i++) send_byte(pattern(pat, i), hold);
    endtask

    // Final byte with exact latency checks; optionally pulse start in FINISH.
    task automatic finish_last(input int pat, input bit start_in_finish);
        sd_dout       = pattern(pat, 511);
        sd_byte_avail = 1'b1;
        tick();
        chk("last_we", buf_we, 1);
        chk("last_waddr", buf_waddr, 511);
        chk("last_done_early", done, 0);
        chk("last_busy", busy, 1);
        sd_byte_avail = 1'b0;
        if (start_in_finish) begin
            start = 1'b1;
            addr  = 32'h99;
        end
        tick();
        chk("done_pulse", done, 1);
        chk("done_busy_low", busy, 0);
        start = 1'b0;
        tick();
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    task automatic check_block(input string tag, input int pat);
        int bad = 0;
        for (int i = 0; i < 512; i++)
            if (mem[i] !== pattern(pat, i)) bad++;
        chk(tag, bad, 0);
    endtask

    // Watchdog
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Directed stimulus
    initial begin
        int w0, d0, r0, got;

        KEY0 = 1'b0; start = 1'b0; addr = 32'h0; sd_ready = 1'b1;
        sd_byte_avail = 1'b0; sd_dout = 8'h00;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_sd_rd", sd_rd, 0);
        chk("rst_buf_we", buf_we, 0);
        chk("rst_sd_addr", sd_addr, 0);
        chk("rst_buf_waddr", buf_waddr, 0);
        KEY0 = 1'b1;
        tick();

        // 1: normal read
        w0 = wr_total; d0 = done_total;
        begin_read(32'h0000_0010);
        chk("t1_busy", busy, 1);
        chk("t1_sd_addr", sd_addr, 32'h10);
        accept();
        run_bytes(0, 0, 510, 1);
        finish_last(0, 1'b0);
        chk("t1_writes", wr_total - w0, 512);
        chk("t1_order", ord_err, 0);
        chk("t1_dones", done_total - d0, 1);
        check_block("t1_data", 0);
        chk("t1_sd_addr_end", sd_addr, 32'h10);
        chk("t1_error", error, 0);

        // 2: long strobe, 40 cycles high per byte
        w0 = wr_total; d0 = done_total;
        begin_read(32'h0000_0200);
        accept();
        run_bytes(1, 0, 510, 40);
        finish_last(1, 1'b0);
        chk("t2_writes", wr_total - w0, 512);
        chk("t2_order", ord_err, 0);
        chk("t2_dones", done_total - d0, 1);
        check_block("t2_data", 1);

        // 3: ready stuck low -> timeout
        sd_ready = 1'b0;
        r0 = rd_cycles; d0 = done_total;
        begin_read(32'h0000_0300);
        repeat (TMO - 1) tick();
        chk("t3_busy_63", busy, 1);
        chk("t3_err_63", error, 0);
        tick();
        chk("t3_busy_64", busy, 1);
        chk("t3_err_64", error, 0);
        tick();
        chk("t3_err_set", error, 1);
        chk("t3_busy_clr", busy, 0);
        repeat (5) tick();
        chk("t3_err_sticky", error, 1);
        chk("t3_no_sd_rd", rd_cycles - r0, 0);
        chk("t3_no_done", done_total - d0, 0);

        // 4: next start clears error; stall after byte 100
        sd_ready = 1'b1;
        w0 = wr_total; d0 = done_total;
        begin_read(32'h0000_0400);
        chk("t4_err_cleared", error, 0);
        chk("t4_busy", busy, 1);
        accept();
        run_bytes(3, 0, 100, 1);
        got = 0;
        for (int i = 0; i < 4 * TMO; i++) begin
            if (error === 1'b1) begin
                got = 1;
                break;
            end
            tick();
        end
        chk("t4_stall_err", got, 1);
        chk("t4_busy_clr", busy, 0);
        chk("t4_writes", wr_total - w0, 101);
        chk("t4_no_done", done_total - d0, 0);

        // 5: reset mid-RECV at byte 300, then a fresh full read
        w0 = wr_total;
        begin_read(32'h0000_0500);
        accept();
        run_bytes(2, 0, 299, 1);
        sd_dout = 8'h5A;
        sd_byte_avail = 1'b1;
        KEY0 = 1'b0;
        tick();
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_error", error, 0);
        chk("t5_sd_rd", sd_rd, 0);
        chk("t5_buf_we", buf_we, 0);
        chk("t5_sd_addr", sd_addr, 0);
        chk("t5_buf_waddr", buf_waddr, 0);
        chk("t5_buf_wdata", buf_wdata, 0);
        KEY0 = 1'b1;
        sd_byte_avail = 1'b0;
        repeat (5) tick();
        chk("t5_writes_before", wr_total - w0, 300);
        w0 = wr_total; d0 = done_total;
        begin_read(32'h0000_0020);
        accept();
        run_bytes(2, 0, 510, 1);
        finish_last(2, 1'b0);
        chk("t5_writes", wr_total - w0, 512);
        chk("t5_order", ord_err, 0);
        chk("t5_dones", done_total - d0, 1);
        check_block("t5_data", 2);

        // 6: start while busy ignored, also start in the FINISH cycle
        w0 = wr_total; d0 = done_total;
        begin_read(32'h0000_0040);
        accept();
        run_bytes(3, 0, 199, 1);
        start = 1'b1;
        addr  = 32'h55;
        tick();
        start = 1'b0;
        chk("t6_sd_addr_hold", sd_addr, 32'h40);
        chk("t6_busy", busy, 1);
        run_bytes(3, 200, 510, 1);
        finish_last(3, 1'b1);
        chk("t6_writes", wr_total - w0, 512);
        chk("t6_dones", done_total - d0, 1);
        chk("t6_sd_addr_end", sd_addr, 32'h40);
        check_block("t6_data", 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
